// File: rtl/tbird_pkg.sv
// Shared types and lamp patterns for the Thunderbird tail-light sequencer.
package tbird_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } tbird_state_e;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_1   = 3'b001;
  localparam logic [2:0] LAMP_2   = 3'b011;
  localparam logic [2:0] LAMP_3   = 3'b111;

  function automatic logic is_left_seq(input tbird_state_e st);
    return (st == L1) || (st == L2) || (st == L3);
  endfunction

  function automatic logic is_right_seq(input tbird_state_e st);
    return (st == R1) || (st == R2) || (st == R3);
  endfunction

endpackage

// File: rtl/tbird_tick.sv
// Prescaler: counts 0..TICK_DIV-1 and strobes tick in the terminal-count cycle.
module tbird_tick #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_r;

  // Free-running divider, wraps at LAST so it never exceeds TICK_DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (count_r == LAST) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + ONE;
    end
  end

  assign tick = (count_r == LAST);

endmodule

// File: rtl/tbird_sequencer.sv
// Arbitrated Thunderbird tail-light controller: one Moore FSM drives both banks.
// Optional brake override enabled by defining TBIRD_BRAKE_EN.
module tbird_sequencer
  import tbird_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       brake,
  output logic [2:0] left_lamps,
  output logic [2:0] right_lamps,
  output logic       tick
);

  logic         tick_s;
  tbird_state_e state_r;
  tbird_state_e next_s;
  logic [2:0]   left_base_s;
  logic [2:0]   right_base_s;

  tbird_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  assign tick = tick_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state: requests are only looked at on a tick; hazard preempts turns
  always_comb begin
    next_s = state_r;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (hazard_req || (left_req && right_req)) begin
            next_s = HAZ;
          end else if (left_req) begin
            next_s = L1;
          end else if (right_req) begin
            next_s = R1;
          end else begin
            next_s = IDLE;
          end
        end
        L1:      next_s = hazard_req ? HAZ : L2;
        L2:      next_s = hazard_req ? HAZ : L3;
        L3:      next_s = hazard_req ? HAZ : IDLE;
        R1:      next_s = hazard_req ? HAZ : R2;
        R2:      next_s = hazard_req ? HAZ : R3;
        R3:      next_s = hazard_req ? HAZ : IDLE;
        HAZ:     next_s = IDLE;
        default: next_s = IDLE;
      endcase
    end else begin
      next_s = state_r;
    end
  end

  // Lamp decode straight from the state register
  always_comb begin
    left_base_s  = LAMP_OFF;
    right_base_s = LAMP_OFF;
    case (state_r)
      IDLE: begin
        left_base_s  = LAMP_OFF;
        right_base_s = LAMP_OFF;
      end
      L1:  left_base_s  = LAMP_1;
      L2:  left_base_s  = LAMP_2;
      L3:  left_base_s  = LAMP_3;
      R1:  right_base_s = LAMP_1;
      R2:  right_base_s = LAMP_2;
      R3:  right_base_s = LAMP_3;
      HAZ: begin
        left_base_s  = LAMP_3;
        right_base_s = LAMP_3;
      end
      default: begin
        left_base_s  = LAMP_OFF;
        right_base_s = LAMP_OFF;
      end
    endcase
  end

`ifdef TBIRD_BRAKE_EN
  // Brake lights every bank that is not currently running a turn sequence
  assign left_lamps  = (brake && !is_left_seq(state_r))  ? LAMP_3 : left_base_s;
  assign right_lamps = (brake && !is_right_seq(state_r)) ? LAMP_3 : right_base_s;
`else
  logic brake_unused_s;
  assign brake_unused_s = brake;
  assign left_lamps     = left_base_s;
  assign right_lamps    = right_base_s;
`endif

endmodule

// File: tb/tb_tbird_sequencer.sv
// Directed, scoreboard-based bench for tbird_sequencer with TICK_DIV=4.
module tb_tbird_sequencer;
  import tbird_pkg::*;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_req = 1'b0;
  logic       right_req = 1'b0;
  logic       hazard_req = 1'b0;
  logic       brake = 1'b0;
  logic [2:0] left_lamps;
  logic [2:0] right_lamps;
  logic       tick;

  logic [5:0] sb[$];
  int         n_evals = 0;
  int         n_fail = 0;

  tbird_sequencer #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset       (reset),
    .left_req    (left_req),
    .right_req   (right_req),
    .hazard_req  (hazard_req),
    .brake       (brake),
    .left_lamps  (left_lamps),
    .right_lamps (right_lamps),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_evals++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Pop the next expected {left,right} pattern and compare; tick must be low here
  task automatic check_lamps(input string tag);
    logic [5:0] e;
    if (sb.size() == 0) begin
      n_evals++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, {2'b00, left_lamps, right_lamps}, {2'b00, e});
      chk({tag, "_tick"}, {7'd0, tick}, 8'd0);
    end
  endtask

  // Wait (bounded) for the next tick, check its spacing, then check lamps after the edge
  task automatic step(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 16);
    chk({tag, "_gap"}, 8'(n), 8'(TD - 1));
    @(negedge clk);
    check_lamps(tag);
  endtask

  task automatic expect_lr(input logic [2:0] l, input logic [2:0] r);
    sb.push_back({l, r});
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    expect_lr(LAMP_OFF, LAMP_OFF);
    check_lamps("reset_init");

    // Left turn held: 001,011,111,000 then repeats
    reset = 1'b0;
    left_req = 1'b1;
    expect_lr(LAMP_1, LAMP_OFF);   step("left_1");
    expect_lr(LAMP_2, LAMP_OFF);   step("left_2");
    expect_lr(LAMP_3, LAMP_OFF);   step("left_3");
    expect_lr(LAMP_OFF, LAMP_OFF); step("left_idle");
    expect_lr(LAMP_1, LAMP_OFF);   step("left_1_again");
    expect_lr(LAMP_2, LAMP_OFF);   step("left_2_again");

    // Reset for 3 clks mid-L2
    reset = 1'b1;
    @(negedge clk);
    expect_lr(LAMP_OFF, LAMP_OFF);
    check_lamps("reset_mid_l2");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    left_req = 1'b0;
    expect_lr(LAMP_OFF, LAMP_OFF); step("first_tick_after_reset");

    // Both turn requests: hazard-style blink
    left_req = 1'b1;
    right_req = 1'b1;
    expect_lr(LAMP_3, LAMP_3);     step("both_haz_1");
    expect_lr(LAMP_OFF, LAMP_OFF); step("both_idle_1");
    expect_lr(LAMP_3, LAMP_3);     step("both_haz_2");
    expect_lr(LAMP_OFF, LAMP_OFF); step("both_idle_2");
    left_req = 1'b0;
    right_req = 1'b0;

    // Right turn preempted by hazard at R2
    right_req = 1'b1;
    expect_lr(LAMP_OFF, LAMP_1);   step("right_1");
    expect_lr(LAMP_OFF, LAMP_2);   step("right_2");
    hazard_req = 1'b1;
    expect_lr(LAMP_3, LAMP_3);     step("hazard_preempt");
    hazard_req = 1'b0;
    right_req = 1'b0;
    expect_lr(LAMP_OFF, LAMP_OFF); step("haz_to_idle");

    // Request dropped after one tick still completes the sequence
    left_req = 1'b1;
    expect_lr(LAMP_1, LAMP_OFF);   step("drop_1");
    left_req = 1'b0;
    expect_lr(LAMP_2, LAMP_OFF);   step("drop_2");
    expect_lr(LAMP_3, LAMP_OFF);   step("drop_3");
    expect_lr(LAMP_OFF, LAMP_OFF); step("drop_idle");
    expect_lr(LAMP_OFF, LAMP_OFF); step("drop_stay_idle");

    // Brake: override only exists when TBIRD_BRAKE_EN is defined
    brake = 1'b1;
    #1;
`ifdef TBIRD_BRAKE_EN
    expect_lr(LAMP_3, LAMP_3);
`else
    expect_lr(LAMP_OFF, LAMP_OFF);
`endif
    chk("brake_idle", {2'b00, left_lamps, right_lamps}, {2'b00, sb.pop_front()});
    left_req = 1'b1;
`ifdef TBIRD_BRAKE_EN
    expect_lr(LAMP_1, LAMP_3);     step("brake_left_1");
    expect_lr(LAMP_2, LAMP_3);     step("brake_left_2");
    left_req = 1'b0;
    expect_lr(LAMP_3, LAMP_3);     step("brake_left_3");
    expect_lr(LAMP_3, LAMP_3);     step("brake_idle_tick");
`else
    expect_lr(LAMP_1, LAMP_OFF);   step("brake_left_1");
    expect_lr(LAMP_2, LAMP_OFF);   step("brake_left_2");
    left_req = 1'b0;
    expect_lr(LAMP_3, LAMP_OFF);   step("brake_left_3");
    expect_lr(LAMP_OFF, LAMP_OFF); step("brake_idle_tick");
`endif
    brake = 1'b0;
    #1;
    expect_lr(LAMP_OFF, LAMP_OFF);
    chk("brake_release", {2'b00, left_lamps, right_lamps}, {2'b00, sb.pop_front()});

    $display("End of test - %0d assertions evaluated, %0d failures", n_evals, n_fail);
    $finish;
  end

endmodule
